// File: rtl/stream_demux_1ton.sv
// Registered 1-to-N stream demultiplexer with valid/ready on the input and every output channel.
// Beats are steered by an explicit select (MODE 0) or by strict round-robin (MODE 1).
module stream_demux_1ton #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_CH   = 4,
  parameter int unsigned SEL_W  = $clog2(N_CH),
  parameter int unsigned MODE   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [DATA_W-1:0]      s_data,
  input  logic [SEL_W-1:0]       s_sel,
  output logic [N_CH-1:0]        m_valid,
  input  logic [N_CH-1:0]        m_ready,
  output logic [N_CH*DATA_W-1:0] m_data,
  output logic                   err,
  output logic [7:0]             drop_cnt
);

  logic [N_CH-1:0]   vld_q, vld_d;
  logic [DATA_W-1:0] dat_q [N_CH];
  logic [DATA_W-1:0] dat_d [N_CH];
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              err_q, err_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  logic [SEL_W-1:0]  tgt;
  logic              sel_oob;
  logic              tgt_free;
  logic              accept;
  logic [N_CH-1:0]   load;

  always_comb begin
    tgt     = (MODE == 0) ? s_sel : rr_ptr_q;
    sel_oob = (MODE == 0) && (32'(s_sel) >= N_CH);
    // A slot is free when empty or being drained this very cycle.
    tgt_free = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (tgt == SEL_W'(c)) tgt_free = !vld_q[c] || m_ready[c];
    end
    s_ready = !rst && (sel_oob || tgt_free);
    accept  = s_valid && s_ready;

    load = '0;
    for (int c = 0; c < N_CH; c++) begin
      load[c]  = accept && !sel_oob && (tgt == SEL_W'(c));
      vld_d[c] = load[c] || (vld_q[c] && !m_ready[c]);
      dat_d[c] = load[c] ? s_data : dat_q[c];
    end

    rr_ptr_d = rr_ptr_q;
    if (MODE == 1 && accept) begin
      rr_ptr_d = (rr_ptr_q == SEL_W'(N_CH - 1)) ? '0 : rr_ptr_q + 1'b1;
    end

    err_d      = accept && sel_oob;
    drop_cnt_d = drop_cnt_q;
    if (err_d && drop_cnt_q != 8'hff) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q      <= '0;
      rr_ptr_q   <= '0;
      err_q      <= 1'b0;
      drop_cnt_q <= '0;
      for (int c = 0; c < N_CH; c++) dat_q[c] <= '0;
    end else begin
      vld_q      <= vld_d;
      rr_ptr_q   <= rr_ptr_d;
      err_q      <= err_d;
      drop_cnt_q <= drop_cnt_d;
      for (int c = 0; c < N_CH; c++) dat_q[c] <= dat_d[c];
    end
  end

  always_comb begin
    m_data = '0;
    for (int c = 0; c < N_CH; c++) m_data[c*DATA_W +: DATA_W] = dat_q[c];
  end

  assign m_valid  = vld_q;
  assign err      = err_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_stream_demux_1ton.sv
// Directed bench for stream_demux_1ton: addressed (4 and 3 channels) and round-robin instances.
module tb_stream_demux_1ton;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Instance A: MODE 0, 4 channels
  logic        a_valid, a_ready, a_err;
  logic [7:0]  a_data, a_drop;
  logic [1:0]  a_sel;
  logic [3:0]  a_mvalid, a_mready;
  logic [31:0] a_mdata;

  // Instance B: MODE 0, 3 channels (select 3 is out of range)
  logic        b_valid, b_ready, b_err;
  logic [7:0]  b_data, b_drop;
  logic [1:0]  b_sel;
  logic [2:0]  b_mvalid, b_mready;
  logic [23:0] b_mdata;

  // Instance R: MODE 1, 4 channels
  logic        r_valid, r_ready, r_err;
  logic [7:0]  r_data, r_drop;
  logic [1:0]  r_sel;
  logic [3:0]  r_mvalid, r_mready;
  logic [31:0] r_mdata;

  stream_demux_1ton #(.DATA_W(8), .N_CH(4), .MODE(0)) u_a (
    .clk(clk), .rst(rst), .s_valid(a_valid), .s_ready(a_ready), .s_data(a_data),
    .s_sel(a_sel), .m_valid(a_mvalid), .m_ready(a_mready), .m_data(a_mdata),
    .err(a_err), .drop_cnt(a_drop)
  );

  stream_demux_1ton #(.DATA_W(8), .N_CH(3), .MODE(0)) u_b (
    .clk(clk), .rst(rst), .s_valid(b_valid), .s_ready(b_ready), .s_data(b_data),
    .s_sel(b_sel), .m_valid(b_mvalid), .m_ready(b_mready), .m_data(b_mdata),
    .err(b_err), .drop_cnt(b_drop)
  );

  stream_demux_1ton #(.DATA_W(8), .N_CH(4), .MODE(1)) u_r (
    .clk(clk), .rst(rst), .s_valid(r_valid), .s_ready(r_ready), .s_data(r_data),
    .s_sel(r_sel), .m_valid(r_mvalid), .m_ready(r_mready), .m_data(r_mdata),
    .err(r_err), .drop_cnt(r_drop)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_valid = 1'b1; a_data = 8'hEE; a_sel = 2'd0; a_mready = 4'h0;
    b_valid = 1'b0; b_data = 8'h00; b_sel = 2'd0; b_mready = 3'h0;
    r_valid = 1'b0; r_data = 8'h00; r_sel = 2'd0; r_mready = 4'h0;
    step();
    step();
    n_cmp++;
    if (a_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_s_ready: got %b want 0", a_ready);
    end
    n_cmp++;
    if (a_mvalid !== 4'h0 || b_mvalid !== 3'h0 || r_mvalid !== 4'h0) begin
      n_err++; $display("FAIL reset_m_valid: got %h/%h/%h want 0", a_mvalid, b_mvalid, r_mvalid);
    end
    n_cmp++;
    if (a_mdata !== 32'h0 || b_mdata !== 24'h0) begin
      n_err++; $display("FAIL reset_m_data: got %h/%h want 0", a_mdata, b_mdata);
    end
    n_cmp++;
    if (a_drop !== 8'd0 || b_drop !== 8'd0 || a_err !== 1'b0) begin
      n_err++; $display("FAIL reset_drop: got cnt %0d err %b want 0", b_drop, a_err);
    end
    a_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_sweep();
    a_mready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      a_valid = 1'b1; a_data = 8'hA0 + 8'(i); a_sel = 2'(i);
      #1;
      n_cmp++;
      if (a_ready !== 1'b1) begin
        n_err++; $display("FAIL sweep_ready[%0d]: got %b want 1", i, a_ready);
      end
      step();
      n_cmp++;
      if (a_mvalid !== 4'(1 << i) || a_mdata[i*8 +: 8] !== 8'hA0 + 8'(i)) begin
        n_err++;
        $display("FAIL sweep_out[%0d]: got v=%b d=%h want v=%b d=%h", i, a_mvalid,
                 a_mdata[i*8 +: 8], 4'(1 << i), 8'hA0 + 8'(i));
      end
    end
    a_valid = 1'b0;
    step();
    n_cmp++;
    if (a_mvalid !== 4'h0) begin
      n_err++; $display("FAIL sweep_drain: got %b want 0000", a_mvalid);
    end
  endtask

  task automatic test_backpressure();
    a_mready = 4'b1011;
    a_valid = 1'b1; a_data = 8'h11; a_sel = 2'd2;
    step();
    a_data = 8'h22;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_cmp++;
      if (a_ready !== 1'b0 || a_mvalid !== 4'b0100 || a_mdata[23:16] !== 8'h11) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got rdy=%b v=%b d=%h want rdy=0 v=0100 d=11", k, a_ready,
                 a_mvalid, a_mdata[23:16]);
      end
      step();
    end
    a_mready = 4'b1111;
    #1;
    n_cmp++;
    if (a_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_release_ready: got %b want 1", a_ready);
    end
    step();
    n_cmp++;
    if (a_mvalid !== 4'b0100 || a_mdata[23:16] !== 8'h22) begin
      n_err++; $display("FAIL bp_swap: got v=%b d=%h want v=0100 d=22", a_mvalid, a_mdata[23:16]);
    end
    a_data = 8'h33; a_sel = 2'd1;
    step();
    n_cmp++;
    if (a_mvalid !== 4'b0010 || a_mdata[15:8] !== 8'h33) begin
      n_err++; $display("FAIL bp_ch1: got v=%b d=%h want v=0010 d=33", a_mvalid, a_mdata[15:8]);
    end
    a_valid = 1'b0;
    step();
  endtask

  task automatic test_invalid_sel();
    b_mready = 3'b111;
    b_valid = 1'b1; b_sel = 2'd3; b_data = 8'h55;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++;
      if (b_ready !== 1'b1) begin
        n_err++; $display("FAIL inv_ready[%0d]: got %b want 1", k, b_ready);
      end
      step();
      n_cmp++;
      if (b_err !== 1'b1 || b_mvalid !== 3'b000) begin
        n_err++; $display("FAIL inv_err[%0d]: got err=%b v=%b want err=1 v=000", k, b_err, b_mvalid);
      end
    end
    b_valid = 1'b0;
    step();
    n_cmp++;
    if (b_err !== 1'b0 || b_drop !== 8'd3) begin
      n_err++; $display("FAIL inv_count3: got err=%b cnt=%0d want err=0 cnt=3", b_err, b_drop);
    end
    b_valid = 1'b1;
    for (int k = 0; k < 252; k++) step();
    n_cmp++;
    if (b_drop !== 8'd255) begin
      n_err++; $display("FAIL inv_reach255: got %0d want 255", b_drop);
    end
    for (int k = 0; k < 48; k++) step();
    b_valid = 1'b0;
    step();
    n_cmp++;
    if (b_drop !== 8'd255 || b_err !== 1'b0) begin
      n_err++; $display("FAIL inv_saturate: got cnt=%0d err=%b want 255/0", b_drop, b_err);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_v [5];
    logic [3:0] rdy   [5];
    exp_v[0] = 4'b0001; exp_v[1] = 4'b0010; exp_v[2] = 4'b0110;
    exp_v[3] = 4'b1010; exp_v[4] = 4'b0011;
    rdy[0] = 4'b1111; rdy[1] = 4'b1101; rdy[2] = 4'b1101; rdy[3] = 4'b1101; rdy[4] = 4'b1101;
    for (int i = 0; i < 5; i++) begin
      r_mready = rdy[i];
      r_valid = 1'b1; r_data = 8'(i); r_sel = 2'($urandom_range(0, 3));
      #1;
      n_cmp++;
      if (r_ready !== 1'b1) begin
        n_err++; $display("FAIL rr_ready[%0d]: got %b want 1", i, r_ready);
      end
      step();
      n_cmp++;
      if (r_mvalid !== exp_v[i] || r_mdata[(i%4)*8 +: 8] !== 8'(i)) begin
        n_err++;
        $display("FAIL rr_out[%0d]: got v=%b d=%h want v=%b d=%h", i, r_mvalid,
                 r_mdata[(i%4)*8 +: 8], exp_v[i], 8'(i));
      end
    end
    r_data = 8'h05; r_sel = 2'($urandom_range(0, 3));
    for (int k = 0; k < 2; k++) begin
      #1;
      n_cmp++;
      if (r_ready !== 1'b0 || r_mdata[15:8] !== 8'h01 || r_mvalid[1] !== 1'b1) begin
        n_err++;
        $display("FAIL rr_stall[%0d]: got rdy=%b v=%b d=%h want rdy=0 ch1=01", k, r_ready,
                 r_mvalid, r_mdata[15:8]);
      end
      step();
    end
    r_mready = 4'b1111;
    step();
    n_cmp++;
    if (r_mvalid !== 4'b0010 || r_mdata[15:8] !== 8'h05) begin
      n_err++; $display("FAIL rr_beat5: got v=%b d=%h want v=0010 d=05", r_mvalid, r_mdata[15:8]);
    end
    r_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    // rr_ptr is 2 here; four beats return it to 2 with channels 3 and 0 stuck.
    r_mready = 4'b0110;
    r_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      r_data = 8'h40 + 8'(i);
      step();
    end
    r_valid = 1'b0;
    step();
    n_cmp++;
    if (r_mvalid !== 4'b1001 || r_mdata[31:24] !== 8'h41 || r_mdata[7:0] !== 8'h42) begin
      n_err++; $display("FAIL mid_setup: got v=%b d=%h want v=1001 d=41xxxx42", r_mvalid, r_mdata);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if (r_mvalid !== 4'h0 || r_mdata !== 32'h0) begin
      n_err++; $display("FAIL mid_reset: got v=%b d=%h want 0", r_mvalid, r_mdata);
    end
    r_mready = 4'b1111;
    r_valid = 1'b1; r_data = 8'h77;
    step();
    r_valid = 1'b0;
    n_cmp++;
    if (r_mvalid !== 4'b0001 || r_mdata[7:0] !== 8'h77) begin
      n_err++; $display("FAIL mid_next: got v=%b d=%h want v=0001 d=77", r_mvalid, r_mdata[7:0]);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_backpressure();
    test_invalid_sel();
    test_round_robin();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
